// File: rtl/apu_gain_sequencer_pkg.sv
// rtl/apu_gain_sequencer_pkg.sv - shared APU constants, FSM states and gain table
package apu_gain_sequencer_pkg;

  localparam int APU_SAMPLE_W  = 24;
  localparam int APU_GAIN_W    = 10;
  localparam int APU_LEVEL_0DB = 19;
  localparam int APU_IDX_W     = 6;
  localparam int APU_PROD_W    = 33;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL_L,
    ST_MUL_R,
    ST_SAT_R,
    ST_OUT
  } state_t;

  // Entries fit in 9 bits, so the 10-bit value is already the zero-extended signed operand.
  function automatic logic [APU_GAIN_W-1:0] gain_factor(input logic [4:0] level);
    case (level)
      5'd0:    return 10'd1;
      5'd1:    return 10'd2;
      5'd2:    return 10'd3;
      5'd3:    return 10'd4;
      5'd4:    return 10'd5;
      5'd5:    return 10'd6;
      5'd6:    return 10'd7;
      5'd7:    return 10'd8;
      5'd8:    return 10'd9;
      5'd9:    return 10'd10;
      5'd10:   return 10'd11;
      5'd11:   return 10'd13;
      5'd12:   return 10'd14;
      5'd13:   return 10'd16;
      5'd14:   return 10'd18;
      5'd15:   return 10'd20;
      5'd16:   return 10'd23;
      5'd17:   return 10'd25;
      5'd18:   return 10'd29;
      5'd19:   return 10'd32;
      5'd20:   return 10'd36;
      5'd21:   return 10'd40;
      5'd22:   return 10'd45;
      5'd23:   return 10'd51;
      5'd24:   return 10'd57;
      5'd25:   return 10'd64;
      5'd26:   return 10'd72;
      5'd27:   return 10'd80;
      5'd28:   return 10'd90;
      5'd29:   return 10'd101;
      5'd30:   return 10'd114;
      default: return 10'd127;
    endcase
  endfunction

  function automatic logic [APU_GAIN_W-1:0] idx_factor(input logic [APU_IDX_W-1:0] idx);
    if (idx == '0) return '0;
    return gain_factor(5'(idx - 6'd1));
  endfunction

endpackage

// File: rtl/apu_gain_sequencer_if.sv
// rtl/apu_gain_sequencer_if.sv - stereo sample pair in/out bus
interface apu_gain_sequencer_if;
  import apu_gain_sequencer_pkg::*;

  logic [APU_SAMPLE_W-1:0] src_left;
  logic [APU_SAMPLE_W-1:0] src_right;
  logic                    src_valid;
  logic [APU_SAMPLE_W-1:0] dst_left;
  logic [APU_SAMPLE_W-1:0] dst_right;
  logic                    dst_valid;

  modport master (
    output src_left, src_right, src_valid,
    input  dst_left, dst_right, dst_valid
  );

  modport slave (
    input  src_left, src_right, src_valid,
    output dst_left, dst_right, dst_valid
  );

endinterface

// File: rtl/apu_sat_shift.sv
// rtl/apu_sat_shift.sv - 33-bit product to 24-bit sample: drop 5 fraction bits, saturate
module apu_sat_shift
  import apu_gain_sequencer_pkg::*;
(
  input  logic [APU_PROD_W-1:0]   product,
  output logic [APU_SAMPLE_W-1:0] result
);

  logic [4:0] top;

  always_comb begin
    top = product[32:28];
    if ((&top) || !(|top)) begin
      result = product[28:5];
    end else if (product[32]) begin
      result = 24'h800000;
    end else begin
      result = 24'h7FFFFF;
    end
  end

endmodule

// File: rtl/apu_gain_sequencer.sv
// rtl/apu_gain_sequencer.sv - ramped gain stage sharing one multiplier between L and R
module apu_gain_sequencer
  import apu_gain_sequencer_pkg::*;
#(
  parameter int RAMP_DIV = 48
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [4:0]          target_level,
  input  logic                mute,
  apu_gain_sequencer_if.slave pdata,
  output logic                busy,
  output logic                muted,
  output logic                overrun
);

  localparam logic [7:0] RAMP_LAST = 8'(RAMP_DIV - 1);

  state_t                         state;
  state_t                         next_state;
  logic signed [APU_SAMPLE_W-1:0] left_q;
  logic signed [APU_SAMPLE_W-1:0] right_q;
  logic signed [APU_SAMPLE_W-1:0] mul_s;
  logic signed [APU_GAIN_W-1:0]   factor_q;
  logic signed [APU_PROD_W-1:0]   product;
  logic signed [APU_PROD_W-1:0]   mul_p;
  logic [APU_SAMPLE_W-1:0]        sat_res;
  logic [APU_IDX_W-1:0]           cur_idx;
  logic [APU_IDX_W-1:0]           tgt_idx;
  logic [7:0]                     ramp_cnt;

  assign tgt_idx = mute ? '0 : APU_IDX_W'(target_level) + 6'd1;
  assign mul_p   = APU_PROD_W'(factor_q) * APU_PROD_W'(mul_s);

  // One product register feeds the single saturator: left in MUL_R, right in SAT_R.
  apu_sat_shift u_sat (
    .product (product),
    .result  (sat_res)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (pdata.src_valid) next_state = ST_MUL_L;
      ST_MUL_L: next_state = ST_MUL_R;
      ST_MUL_R: next_state = ST_SAT_R;
      ST_SAT_R: next_state = ST_OUT;
      ST_OUT:   next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    busy  = (state != ST_IDLE);
    mul_s = (state == ST_MUL_L) ? left_q : right_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      left_q          <= '0;
      right_q         <= '0;
      factor_q        <= '0;
      product         <= '0;
      cur_idx         <= '0;
      ramp_cnt        <= '0;
      muted           <= 1'b1;
      overrun         <= 1'b0;
      pdata.dst_left  <= '0;
      pdata.dst_right <= '0;
      pdata.dst_valid <= 1'b0;
    end else begin
      muted <= (cur_idx == '0);
      if (pdata.src_valid && state != ST_IDLE) overrun <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (pdata.src_valid) begin
            left_q   <= pdata.src_left;
            right_q  <= pdata.src_right;
            factor_q <= idx_factor(cur_idx);
          end
        end
        ST_MUL_L: product <= mul_p;
        ST_MUL_R: begin
          product        <= mul_p;
          pdata.dst_left <= sat_res;
        end
        ST_SAT_R: begin
          pdata.dst_right <= sat_res;
          pdata.dst_valid <= 1'b1;
        end
        ST_OUT: begin
          pdata.dst_valid <= 1'b0;
          // Direction is re-evaluated every pair, so a new target mid-ramp reverses cleanly.
          if (cur_idx == tgt_idx) begin
            ramp_cnt <= '0;
          end else if (ramp_cnt == RAMP_LAST) begin
            cur_idx  <= (tgt_idx > cur_idx) ? cur_idx + 6'd1 : cur_idx - 6'd1;
            ramp_cnt <= '0;
          end else begin
            ramp_cnt <= ramp_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_apu_gain_sequencer.sv
// tb/tb_apu_gain_sequencer.sv - directed bench for two sequencers (RAMP_DIV 1 and 2)
module tb_apu_gain_sequencer;

  logic        clk;
  logic        rst;
  logic [4:0]  tl;
  logic        mu;
  logic [23:0] sl;
  logic [23:0] sr;
  logic        sv;
  logic        busy1, muted1, ovr1;
  logic        busy2, muted2, ovr2;

  int checks = 0;
  int errors = 0;
  int npair  = 0;

  int tbl [32] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 13, 14, 16, 18, 20,
                   23, 25, 29, 32, 36, 40, 45, 51, 57, 64, 72, 80, 90, 101, 114, 127};
  int div   [2] = '{1, 2};
  int m_idx [2];
  int m_cnt [2];

  logic [23:0] o_l [2];
  logic [23:0] o_r [2];
  logic        o_v [2];
  logic [15:0] h1, h2;
  logic [23:0] prev;
  logic        seen;

  apu_gain_sequencer_if i1 ();
  apu_gain_sequencer_if i2 ();

  assign i1.src_left  = sl;
  assign i1.src_right = sr;
  assign i1.src_valid = sv;
  assign i2.src_left  = sl;
  assign i2.src_right = sr;
  assign i2.src_valid = sv;

  apu_gain_sequencer #(.RAMP_DIV(1)) u_dut1 (
    .clk(clk), .rst(rst), .target_level(tl), .mute(mu), .pdata(i1),
    .busy(busy1), .muted(muted1), .overrun(ovr1)
  );

  apu_gain_sequencer #(.RAMP_DIV(2)) u_dut2 (
    .clk(clk), .rst(rst), .target_level(tl), .mute(mu), .pdata(i2),
    .busy(busy2), .muted(muted2), .overrun(ovr2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] exp_out(input logic [23:0] x, input int idx);
    longint p;
    longint f;
    f = (idx == 0) ? 0 : longint'(tbl[idx-1]);
    p = longint'($signed(x)) * f;
    if (p > 64'sd268435455)  return 24'h7FFFFF;
    if (p < -64'sd268435456) return 24'h800000;
    return 24'(p >>> 5);
  endfunction

  task automatic model_step();
    int tgt;
    tgt = mu ? 0 : int'(tl) + 1;
    for (int d = 0; d < 2; d++) begin
      if (m_idx[d] == tgt) m_cnt[d] = 0;
      else if (m_cnt[d] == div[d] - 1) begin
        m_idx[d] = (tgt > m_idx[d]) ? m_idx[d] + 1 : m_idx[d] - 1;
        m_cnt[d] = 0;
      end else m_cnt[d]++;
    end
  endtask

  task automatic pair(input logic [23:0] l, input logic [23:0] r);
    @(negedge clk); sl = l; sr = r; sv = 1'b1;
    @(negedge clk); sv = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    o_l[0] = i1.dst_left; o_r[0] = i1.dst_right; o_v[0] = i1.dst_valid;
    o_l[1] = i2.dst_left; o_r[1] = i2.dst_right; o_v[1] = i2.dst_valid;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("pair%0d_d%0d_valid", npair, d), 32'(o_v[d]), 32'd1);
      check($sformatf("pair%0d_d%0d_left", npair, d), 32'(o_l[d]), 32'(exp_out(l, m_idx[d])));
      check($sformatf("pair%0d_d%0d_right", npair, d), 32'(o_r[d]), 32'(exp_out(r, m_idx[d])));
    end
    model_step();
    npair++;
    repeat (3) @(negedge clk);
  endtask

  task automatic strobe_pattern(input logic [15:0] when);
    h1 = '0; h2 = '0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (c > 0) begin
        h1[c-1] = i1.dst_valid;
        h2[c-1] = i2.dst_valid;
      end
      sv = when[c];
    end
    sv = 1'b0;
  endtask

  task automatic check_reset_state(input string ph);
    check({ph, "_d1_left"},    32'(i1.dst_left),  32'd0);
    check({ph, "_d1_right"},   32'(i1.dst_right), 32'd0);
    check({ph, "_d1_valid"},   32'(i1.dst_valid), 32'd0);
    check({ph, "_d1_busy"},    32'(busy1),        32'd0);
    check({ph, "_d1_muted"},   32'(muted1),       32'd1);
    check({ph, "_d1_overrun"}, 32'(ovr1),         32'd0);
    check({ph, "_d2_left"},    32'(i2.dst_left),  32'd0);
    check({ph, "_d2_valid"},   32'(i2.dst_valid), 32'd0);
    check({ph, "_d2_busy"},    32'(busy2),        32'd0);
    check({ph, "_d2_muted"},   32'(muted2),       32'd1);
    check({ph, "_d2_overrun"}, 32'(ovr2),         32'd0);
  endtask

  initial begin
    rst = 1'b1; tl = 5'd0; mu = 1'b0; sl = '0; sr = '0; sv = 1'b0;
    m_idx = '{0, 0}; m_cnt = '{0, 0};
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    rst = 1'b0;

    // Soft start from mute to 0 dB
    tl = 5'd19;
    prev = '0;
    for (int p = 0; p < 40; p++) begin
      pair(24'h123456, 24'd32);
      if (p == 0) check("softstart_first_zero", 32'(o_l[0]), 32'd0);
      if (p < 20) check("softstart_monotonic", 32'(o_l[0] >= prev), 32'd1);
      prev = o_l[0];
    end
    pair(24'h123456, 24'd32);
    check("softstart_d1_unity", 32'(o_l[0]), 32'h123456);
    check("softstart_d2_unity", 32'(o_l[1]), 32'h123456);
    check("softstart_d1_factor", 32'(o_r[0]), 32'd32);
    check("unmuted_flag", 32'(muted1), 32'd0);

    // Latency and minimum spacing
    strobe_pattern(16'h0021);
    model_step(); model_step();
    check("spacing5_d1_valid_hist", 32'(h1), 32'h0108);
    check("spacing5_d2_valid_hist", 32'(h2), 32'h0108);
    check("spacing5_no_overrun", 32'(ovr1), 32'd0);
    strobe_pattern(16'h0005);
    model_step();
    check("spacing2_d1_valid_hist", 32'(h1), 32'h0008);
    check("spacing2_d2_valid_hist", 32'(h2), 32'h0008);
    check("spacing2_overrun", 32'(ovr2), 32'd1);

    // Soft mute and release
    mu = 1'b1;
    for (int p = 0; p < 40; p++) begin
      pair(24'h123456, 24'd32);
      if (p == 2) check("mute_d2_step_every_two", 32'(o_r[1]), 32'd29);
    end
    pair(24'h123456, 24'd32);
    check("mute_d2_left_zero", 32'(o_l[1]), 32'd0);
    check("mute_d1_muted", 32'(muted1), 32'd1);
    check("mute_d2_muted", 32'(muted2), 32'd1);
    check("overrun_sticky", 32'(ovr1), 32'd1);
    mu = 1'b0;
    for (int p = 0; p < 40; p++) pair(24'h123456, 24'd32);
    pair(24'h123456, 24'd32);
    check("unmute_d2_unity", 32'(o_l[1]), 32'h123456);

    // Saturation at the top level
    tl = 5'd31;
    for (int p = 0; p < 24; p++) pair(24'h000100, 24'd32);
    pair(24'h400000, 24'hC00000);
    check("sat_d1_pos", 32'(o_l[0]), 32'h7FFFFF);
    check("sat_d1_neg", 32'(o_r[0]), 32'h800000);
    check("sat_d2_pos", 32'(o_l[1]), 32'h7FFFFF);
    check("sat_d2_neg", 32'(o_r[1]), 32'h800000);
    pair(24'h000100, 24'd32);
    check("sat_small_left", 32'(o_l[1]), 32'h0003F8);
    check("sat_small_factor", 32'(o_r[1]), 32'd127);

    // Reset while the pair is in MUL_R
    @(negedge clk); sl = 24'h123456; sr = 24'h123456; sv = 1'b1;
    @(negedge clk); sv = 1'b0;
    @(negedge clk);
    check("midpair_busy", 32'(busy1), 32'd1);
    rst = 1'b1;
    #1;
    check_reset_state("midpair_reset");
    m_idx = '{0, 0}; m_cnt = '{0, 0};
    seen = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      seen = seen | i1.dst_valid | i2.dst_valid;
    end
    check("midpair_no_strobe", 32'(seen), 32'd0);

    // Retarget while ramping up
    tl = 5'd19;
    for (int p = 0; p < 10; p++) pair(24'h123456, 24'd32);
    tl = 5'd4;
    pair(24'h123456, 24'd32);
    check("retarget_d1_at10", 32'(o_r[0]), 32'd10);
    pair(24'h123456, 24'd32);
    check("retarget_d1_reversed", 32'(o_r[0]), 32'd9);
    for (int p = 0; p < 6; p++) pair(24'h123456, 24'd32);
    pair(24'h123456, 24'd32);
    check("retarget_d1_settled", 32'(o_r[0]), 32'd5);
    check("retarget_d2_settled", 32'(o_r[1]), 32'd5);
    check("retarget_d1_left", 32'(o_l[0]), 32'h02D82D);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
